// File: rtl/counter_ctrl.sv
// Stopwatch-style control FSM: button edge detect, tick prescaler and a shadow
// count that drives a separate display counter through cnt_en / cnt_clr.
module counter_ctrl #(
   parameter int unsigned DIV       = 4,
   parameter int unsigned MAX_COUNT = 99,
   parameter int unsigned WRAP      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       clr_btn,
   input  logic       mode_up,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       cnt_up,
   output logic [6:0] count,
   output logic [1:0] state,
   output logic       done
);

   localparam int unsigned     PW         = $clog2(DIV);
   localparam int unsigned     CW         = 7;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
   localparam logic [CW-1:0]   CNT_MAX    = CW'(MAX_COUNT);
   localparam bit              WRAP_EN    = (WRAP != 32'd0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            up_q, up_d;
   logic            done_q, done_d;
   logic            start_q, stop_q, clr_q;

   logic            start_press, stop_press, clr_press;
   logic            tick, terminal;

   assign start_press = start_btn & ~start_q;
   assign stop_press  = stop_btn  & ~stop_q;
   assign clr_press   = clr_btn   & ~clr_q;

   assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   assign terminal = tick && (up_q ? (count_q == CNT_MAX) : (count_q == '0));

   // Enable is withheld on a clear or on a terminal tick that stops in DONE
   assign cnt_en  = !rst && tick && !clr_press && !(terminal && !WRAP_EN);
   assign cnt_clr = !rst && clr_press;

   assign cnt_up = up_q;
   assign count  = count_q;
   assign state  = state_q;
   assign done   = done_q;

   // Button history loads raw levels even in reset so a held button never presses
   always_ff @(posedge clk) begin
      start_q <= start_btn;
      stop_q  <= stop_btn;
      clr_q   <= clr_btn;
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         presc_q <= '0;
         up_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         up_q    <= up_d;
         done_q  <= done_d;
      end
   end

   // Next-state: clear wins over everything; stop in RUN freezes presc unless it wraps
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      up_d    = up_q;
      if (clr_press) begin
         state_d = ST_IDLE;
         count_d = '0;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_press) begin
                  state_d = ST_RUN;
                  presc_d = '0;
                  up_d    = mode_up;
               end
            end
            ST_RUN: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (stop_press) begin
                  state_d = ST_PAUSE;
                  if (!tick) presc_d = presc_q;
               end
               if (tick) begin
                  if (!terminal) begin
                     count_d = up_q ? count_q + CW'(1) : count_q - CW'(1);
                  end else if (WRAP_EN) begin
                     count_d = up_q ? '0 : CNT_MAX;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               if (start_press) state_d = ST_RUN;
            end
            default: begin
            end
         endcase
      end
      done_d = (state_d == ST_DONE);
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl (DIV=4, MAX_COUNT=3) with a WRAP=0 and a WRAP=1
// instance sharing the same buttons; expectations flow through a scoreboard queue.
module tb_counter_ctrl;

   typedef struct packed {
      logic       en;
      logic       clr;
      logic [1:0] st;
      logic [6:0] cnt;
      logic       up;
      logic       done;
   } obs_t;

   typedef struct packed {
      obs_t e0;
      obs_t e1;
      logic chk1;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst, start_btn, stop_btn, clr_btn, mode_up;
   logic       en0, clr0, up0, done0, en1, clr1, up1, done1;
   logic [6:0] cnt0, cnt1;
   logic [1:0] st0, st1;

   sb_t sbq[$];
   int  n_cmp   = 0;
   int  n_bad   = 0;
   int  step_no = 0;

   always #5 clk = ~clk;

   counter_ctrl #(.DIV(4), .MAX_COUNT(3), .WRAP(0)) dut (
      .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
      .clr_btn(clr_btn), .mode_up(mode_up), .cnt_en(en0), .cnt_clr(clr0),
      .cnt_up(up0), .count(cnt0), .state(st0), .done(done0)
   );

   counter_ctrl #(.DIV(4), .MAX_COUNT(3), .WRAP(1)) dut_w (
      .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
      .clr_btn(clr_btn), .mode_up(mode_up), .cnt_en(en1), .cnt_clr(clr1),
      .cnt_up(up1), .count(cnt1), .state(st1), .done(done1)
   );

   function automatic obs_t E(input logic en, input logic clr, input logic [1:0] st,
                              input int cnt, input logic up);
      obs_t r;
      r.en   = en;
      r.clr  = clr;
      r.st   = st;
      r.cnt  = 7'(cnt);
      r.up   = up;
      r.done = (st == 2'b11);
      return r;
   endfunction

   task automatic check_one(input string tag, input obs_t obs, input obs_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s step %0d: observed en=%b clr=%b st=%b cnt=%0d up=%b done=%b, expected en=%b clr=%b st=%b cnt=%0d up=%b done=%b",
                tag, step_no, obs.en, obs.clr, obs.st, obs.cnt, obs.up, obs.done,
                exp.en, exp.clr, exp.st, exp.cnt, exp.up, exp.done);
      end
   endtask

   task automatic stepx(input logic s, input logic p, input logic c, input logic m,
                        input obs_t e0, input logic chk1, input obs_t e1);
      sb_t  ex;
      obs_t o0, o1;
      start_btn = s;
      stop_btn  = p;
      clr_btn   = c;
      mode_up   = m;
      sbq.push_back('{e0, e1, chk1});
      @(negedge clk);
      ex = sbq.pop_front();
      o0 = {en0, clr0, st0, cnt0, up0, done0};
      o1 = {en1, clr1, st1, cnt1, up1, done1};
      check_one("dut", o0, ex.e0);
      if (ex.chk1) check_one("dut_wrap", o1, ex.e1);
      step_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic step0(input logic s, input logic p, input logic c, input logic m, input obs_t e0);
      stepx(s, p, c, m, e0, 1'b0, '0);
   endtask

   task automatic step2(input logic s, input logic p, input logic c, input logic m,
                        input obs_t e0, input obs_t e1);
      stepx(s, p, c, m, e0, 1'b1, e1);
   endtask

   task automatic stepb(input logic s, input logic p, input logic c, input logic m, input obs_t e);
      stepx(s, p, c, m, e, 1'b1, e);
   endtask

   initial begin
      rst = 1'b1; start_btn = 1'b1; stop_btn = 1'b0; clr_btn = 1'b0; mode_up = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // clear edge while in reset must not pulse cnt_clr
      stepb(1, 0, 1, 1, E(0, 0, 0, 0, 1));
      rst = 1'b0;
      // start held through reset: no press until released and pressed again
      stepb(1, 0, 0, 1, E(0, 0, 0, 0, 1));
      stepb(1, 0, 0, 1, E(0, 0, 0, 0, 1));
      stepb(0, 0, 0, 1, E(0, 0, 0, 0, 1));
      stepb(1, 0, 0, 1, E(0, 0, 0, 0, 1));
      // up count: ticks every 4th RUN cycle
      for (int k = 0; k < 15; k++) stepb(0, 0, 0, 1, E(k % 4 == 3, 0, 1, k / 4, 1));
      // terminal tick: WRAP=0 holds and goes DONE, WRAP=1 wraps to 0
      step2(0, 0, 0, 1, E(0, 0, 1, 3, 1), E(1, 0, 1, 3, 1));
      step2(1, 0, 0, 1, E(0, 0, 3, 3, 1), E(0, 0, 1, 0, 1));
      step2(0, 1, 0, 1, E(0, 0, 3, 3, 1), E(0, 0, 1, 0, 1));
      step2(0, 0, 0, 1, E(0, 0, 3, 3, 1), E(0, 0, 2, 0, 1));
      step2(0, 0, 1, 1, E(0, 1, 3, 3, 1), E(0, 1, 2, 0, 1));
      stepb(0, 0, 0, 1, E(0, 0, 0, 0, 1));
      // pause at presc=2, resume ticks 2 cycles later
      stepb(1, 0, 0, 1, E(0, 0, 0, 0, 1));
      stepb(0, 0, 0, 1, E(0, 0, 1, 0, 1));
      stepb(0, 0, 0, 1, E(0, 0, 1, 0, 1));
      stepb(0, 1, 0, 1, E(0, 0, 1, 0, 1));
      stepb(0, 1, 0, 1, E(0, 0, 2, 0, 1));
      for (int k = 0; k < 9; k++) stepb(0, 0, 0, 1, E(0, 0, 2, 0, 1));
      stepb(1, 0, 0, 1, E(0, 0, 2, 0, 1));
      stepb(0, 0, 0, 1, E(0, 0, 1, 0, 1));
      stepb(0, 0, 0, 1, E(1, 0, 1, 0, 1));
      // simultaneous start+stop: RUN takes stop, PAUSE takes start
      stepb(1, 1, 0, 1, E(0, 0, 1, 1, 1));
      stepb(0, 0, 0, 1, E(0, 0, 2, 1, 1));
      stepb(1, 1, 0, 1, E(0, 0, 2, 1, 1));
      for (int k = 0; k < 3; k++) stepb(0, 0, 0, 1, E(0, 0, 1, 1, 1));
      // stop coinciding with a tick still counts
      stepb(0, 1, 0, 1, E(1, 0, 1, 1, 1));
      stepb(0, 0, 0, 1, E(0, 0, 2, 2, 1));
      stepb(1, 0, 0, 1, E(0, 0, 2, 2, 1));
      for (int k = 0; k < 3; k++) stepb(0, 0, 0, 1, E(0, 0, 1, 2, 1));
      // clear coinciding with a tick at count=2
      stepb(0, 0, 1, 1, E(0, 1, 1, 2, 1));
      stepb(0, 0, 0, 1, E(0, 0, 0, 0, 1));
      // down from 0; mode_up ignored once running
      stepb(1, 0, 0, 0, E(0, 0, 0, 0, 1));
      for (int k = 0; k < 3; k++) stepb(0, 0, 0, 1, E(0, 0, 1, 0, 0));
      step2(0, 0, 0, 1, E(0, 0, 1, 0, 0), E(1, 0, 1, 0, 0));
      for (int k = 0; k < 3; k++) step2(0, 0, 0, 1, E(0, 0, 3, 0, 0), E(0, 0, 1, 3, 0));
      step2(0, 0, 0, 1, E(0, 0, 3, 0, 0), E(1, 0, 1, 3, 0));
      step2(0, 0, 1, 1, E(0, 1, 3, 0, 0), E(0, 1, 1, 2, 0));
      stepb(0, 0, 0, 1, E(0, 0, 0, 0, 0));
      // reset mid-RUN on a tick cycle with a clear edge: both outputs gated
      step0(1, 0, 0, 1, E(0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) step0(0, 0, 0, 1, E(0, 0, 1, 0, 1));
      step0(0, 0, 0, 1, E(1, 0, 1, 0, 1));
      for (int k = 0; k < 3; k++) step0(0, 0, 0, 1, E(0, 0, 1, 1, 1));
      rst = 1'b1;
      step0(0, 0, 1, 1, E(0, 0, 1, 1, 1));
      rst = 1'b0;
      step0(0, 0, 1, 1, E(0, 0, 0, 0, 1));
      step0(0, 0, 0, 1, E(0, 0, 0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
